uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO. Frames are
// start, DATA_W data bits LSB first, optional parity, then stop bits.
module uart_tx_fifo #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 16,
  parameter int DEPTH     = 4,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [2:0]               dbg_state
);

  localparam int   AW  = $clog2(DEPTH);
  localparam int   LW  = AW + 1;
  localparam int   DW  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int   BW  = $clog2(DATA_W);
  localparam logic HAS_PAR = (PARITY != 0);
  localparam logic ODD_PAR = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic [LW-1:0]     level_q, level_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push, pop, div_end;

  // Handshake: a word transfers on a rising edge where wr_valid and wr_ready
  // are both high; wr_valid may stay high while wr_ready is low (no effect).
  assign wr_ready  = (level_q < LW'(DEPTH));
  assign push      = wr_valid && wr_ready;
  assign div_end   = (div_q == DW'(CLK_DIV - 1));
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign level     = level_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (level_q != '0) pop = 1'b1;
      end
      START: begin
        if (div_end) begin
          state_d = DATA;
          div_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DATA: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == BW'(DATA_W - 1)) begin
            bit_d = '0;
            if (HAS_PAR) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      PAR: begin
        if (div_end) begin
          state_d = STOP;
          div_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      STOP: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Starting a frame always pops the head word, from IDLE or straight out of STOP.
    if (pop) begin
      state_d = START;
      div_d   = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      shift_d = mem_q[rd_ptr_q];
      par_d   = (^mem_q[rd_ptr_q]) ^ ODD_PAR;
    end
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed frame sequences and random
// traffic checked against a timeline model of frame start times.
module tb_uart_tx_fifo;

  localparam int CD    = 16;
  localparam int DW    = 8;
  localparam int DEP   = 4;
  localparam int FRAME = (1 + DW + 1) * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       wv0 = 1'b0, rdy0, tx0, busy0;
  logic [7:0] wd0 = '0;
  logic [2:0] lvl0, st0;
  logic       wv1 = 1'b0, rdy1, tx1, busy1;
  logic [7:0] wd1 = '0;
  logic [2:0] lvl1, st1;
  logic       wv2 = 1'b0, rdy2, tx2, busy2;
  logic [7:0] wd2 = '0;
  logic [2:0] lvl2, st2;
  logic       wv3 = 1'b0, rdy3, tx3, busy3;
  logic [6:0] wd3 = '0;
  logic [2:0] lvl3, st3;

  uart_tx_fifo u0 (.clock(clk), .reset(rst), .wr_valid(wv0), .wr_ready(rdy0), .wr_data(wd0),
                   .tx(tx0), .busy(busy0), .level(lvl0), .dbg_state(st0));
  uart_tx_fifo #(.PARITY(1)) u1 (.clock(clk), .reset(rst), .wr_valid(wv1), .wr_ready(rdy1),
                   .wr_data(wd1), .tx(tx1), .busy(busy1), .level(lvl1), .dbg_state(st1));
  uart_tx_fifo #(.PARITY(2)) u2 (.clock(clk), .reset(rst), .wr_valid(wv2), .wr_ready(rdy2),
                   .wr_data(wd2), .tx(tx2), .busy(busy2), .level(lvl2), .dbg_state(st2));
  uart_tx_fifo #(.DATA_W(7), .CLK_DIV(4), .STOP_BITS(2)) u3 (.clock(clk), .reset(rst),
                   .wr_valid(wv3), .wr_ready(rdy3), .wr_data(wd3), .tx(tx3), .busy(busy3),
                   .level(lvl3), .dbg_state(st3));

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference: each accepted word gets a start edge = max(accept+1, end of previous frame).
  int         q_start[$];
  logic [7:0] q_data[$];
  int         last_end = 0;
  bit         last_acc = 0;
  logic [7:0] exp_q[$];

  task check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_n, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [8:0] d, input int dw, input int par, input int k);
    logic p;
    p = 1'b0;
    for (int i = 0; i < dw; i++) p ^= d[i];
    if (k == 0) return 1'b0;
    if (k <= dw) return d[k-1];
    if (par != 0 && k == dw + 1) return (par == 2) ? ~p : p;
    return 1'b1;
  endfunction

  function automatic int m_level(input int e);
    int n;
    n = 0;
    foreach (q_start[i]) if (q_start[i] > e) n++;
    return n;
  endfunction

  function automatic logic m_tx(input int e);
    foreach (q_start[i])
      if (e >= q_start[i] && e < q_start[i] + FRAME)
        return frame_bit({1'b0, q_data[i]}, DW, 0, (e - q_start[i]) / CD);
    return 1'b1;
  endfunction

  function automatic logic m_busy(input int e);
    foreach (q_start[i]) if (e >= q_start[i] && e < q_start[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  task model_edge(input logic r, input logic v, input logic [7:0] d);
    int s;
    int lvl_before;
    last_acc = 0;
    lvl_before = m_level(edge_n - 1);
    while (q_start.size() > 0 && q_start[0] + FRAME <= edge_n) begin
      void'(q_start.pop_front());
      void'(q_data.pop_front());
    end
    if (r) begin
      q_start.delete();
      q_data.delete();
      last_end = edge_n;
    end else if (v && lvl_before < DEP) begin
      s = (edge_n + 1 > last_end) ? edge_n + 1 : last_end;
      q_start.push_back(s);
      q_data.push_back(d);
      last_end = s + FRAME;
      last_acc = 1;
    end
  endtask

  task cycle();
    @(posedge clk);
    edge_n++;
    model_edge(rst, wv0, wd0);
    #1;
    check("m_tx", 32'(tx0), 32'(m_tx(edge_n)));
    check("m_busy", 32'(busy0), 32'(m_busy(edge_n)));
    check("m_level", 32'(lvl0), 32'(m_level(edge_n)));
    check("m_ready", 32'(rdy0), 32'(m_level(edge_n) < DEP));
  endtask

  typedef struct packed {
    logic       rst;
    logic       wv;
    logic [7:0] wd;
    logic [2:0] lvl;
    logic       rdy;
    logic       bsy;
    logic       txv;
  } vec_t;
  vec_t vt[11];

  logic line_q[$];
  logic line1[200], line2[200], line3[200];

  initial begin
    int next, full_lvl, busy_cnt, low_cnt, b1, b2, b3;
    bit rec, rdy_low_seen;
    logic [7:0] got;

    vt[0]  = '{1'b1, 1'b1, 8'hAA, 3'd0, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 8'h01, 3'd1, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 8'h03, 3'd2, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 8'h04, 3'd3, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 8'h05, 3'd4, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 8'h06, 3'd4, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 8'h07, 3'd0, 1'b1, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      rst = vt[i].rst; wv0 = vt[i].wv; wd0 = vt[i].wd;
      cycle();
      check($sformatf("vec%0d_level", i), 32'(lvl0), 32'(vt[i].lvl));
      check($sformatf("vec%0d_ready", i), 32'(rdy0), 32'(vt[i].rdy));
      check($sformatf("vec%0d_busy", i), 32'(busy0), 32'(vt[i].bsy));
      check($sformatf("vec%0d_tx", i), 32'(tx0), 32'(vt[i].txv));
    end
    wv0 = 1'b0;

    // Single 0x55 frame with default parameters.
    wv0 = 1'b1; wd0 = 8'h55;
    cycle();
    wv0 = 1'b0;
    check("a_level_after_write", 32'(lvl0), 32'd1);
    busy_cnt = 0; low_cnt = 0;
    for (int c = 0; c < 199; c++) begin
      cycle();
      if (c == 0) check("a_level_after_pop", 32'(lvl0), 32'd0);
      if (busy0) busy_cnt++;
      if (!tx0) low_cnt++;
    end
    check("a_busy_cycles", 32'(busy_cnt), 32'd160);
    check("a_low_cycles", 32'(low_cnt), 32'd80);

    // Held wr_valid with 0x01..0x06: back-to-back frames, strict order.
    next = 1; wv0 = 1'b1; wd0 = 8'h01; full_lvl = -1; rdy_low_seen = 0;
    busy_cnt = 0; rec = 0;
    line_q.delete();
    for (int c = 0; c < 1100; c++) begin
      cycle();
      if (last_acc) begin exp_q.push_back(wd0); next++; end
      if (next > 6) wv0 = 1'b0; else wd0 = 8'(next);
      if (!rdy0 && !rdy_low_seen) begin rdy_low_seen = 1; full_lvl = int'(lvl0); end
      if (busy0) busy_cnt++;
      if (!tx0) rec = 1;
      if (rec) line_q.push_back(tx0);
    end
    check("b_level_at_ready_low", 32'(full_lvl), 32'd4);
    check("b_busy_cycles", 32'(busy_cnt), 32'd960);
    check("b_line_length", 32'(line_q.size() >= 960), 32'd1);
    for (int f = 0; f < 6; f++) begin
      int base;
      base = f * 160;
      got = '0;
      for (int b = 0; b < 8; b++)
        got[b] = (base + 16 * (1 + b) + 8 < line_q.size()) ? line_q[base + 16 * (1 + b) + 8] : 1'bx;
      check($sformatf("b_start%0d", f), 32'((base + 8 < line_q.size()) ? line_q[base + 8] : 1'bx), 32'd0);
      check($sformatf("b_stop%0d", f),
            32'((base + 152 < line_q.size()) ? line_q[base + 152] : 1'bx), 32'd1);
      check($sformatf("b_byte%0d", f), 32'(got), 32'((exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx));
    end

    // Write landing on the edge the last stop bit ends, with an empty FIFO.
    wv0 = 1'b1; wd0 = 8'h81;
    cycle();
    wv0 = 1'b0;
    repeat (160) cycle();
    check("c_busy_last_stop", 32'(busy0), 32'd1);
    wv0 = 1'b1; wd0 = 8'h42;
    cycle();
    wv0 = 1'b0;
    check("c_idle_tx", 32'(tx0), 32'd1);
    check("c_idle_busy", 32'(busy0), 32'd0);
    check("c_idle_level", 32'(lvl0), 32'd1);
    cycle();
    check("c_start_tx", 32'(tx0), 32'd0);
    check("c_start_busy", 32'(busy0), 32'd1);
    check("c_start_level", 32'(lvl0), 32'd0);
    repeat (170) cycle();

    // Reset during data bit 3 of the first of three queued frames.
    wv0 = 1'b1; wd0 = 8'hA5;
    cycle();
    wd0 = 8'h3C;
    cycle();
    wd0 = 8'hF0;
    cycle();
    wv0 = 1'b0;
    repeat (68) cycle();
    check("d_level_pre", 32'(lvl0), 32'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("d_rst_tx", 32'(tx0), 32'd1);
    check("d_rst_level", 32'(lvl0), 32'd0);
    check("d_rst_busy", 32'(busy0), 32'd0);
    low_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (!tx0) low_cnt++;
    end
    check("d_no_low_after_rst", 32'(low_cnt), 32'd0);

    // Random traffic with varying write density and rare resets.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      wv0 = ($urandom_range(0, 7) <= (c / 500));
      wd0 = 8'($urandom);
      cycle();
    end
    rst = 1'b0; wv0 = 1'b0;
    repeat (700) cycle();

    // Parity and short-frame variants.
    wv1 = 1'b1; wd1 = 8'h07;
    wv2 = 1'b1; wd2 = 8'h07;
    wv3 = 1'b1; wd3 = 7'h7F;
    cycle();
    wv1 = 1'b0; wv2 = 1'b0; wv3 = 1'b0;
    b1 = 0; b2 = 0; b3 = 0; low_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      cycle();
      line1[c] = tx1; line2[c] = tx2; line3[c] = tx3;
      if (busy1) b1++;
      if (busy2) b2++;
      if (busy3) b3++;
      if (c < 40 && !tx3) low_cnt++;
    end
    check("f_even_frame", 32'(b1), 32'd176);
    check("f_odd_frame", 32'(b2), 32'd176);
    check("f_short_frame", 32'(b3), 32'd40);
    check("f_even_parity", 32'(line1[9 * 16 + 8]), 32'd1);
    check("f_odd_parity", 32'(line2[9 * 16 + 8]), 32'd0);
    check("f_short_low", 32'(low_cnt), 32'd4);
    for (int k = 0; k < 11; k++) begin
      check($sformatf("f_even_bit%0d", k), 32'(line1[k * 16 + 8]), 32'(frame_bit(9'h007, 8, 1, k)));
      check($sformatf("f_odd_bit%0d", k), 32'(line2[k * 16 + 8]), 32'(frame_bit(9'h007, 8, 2, k)));
    end
    for (int k = 0; k < 10; k++)
      check($sformatf("f_short_bit%0d", k), 32'(line3[k * 4 + 2]), 32'(frame_bit(9'h07F, 7, 0, k)));
    check("f_short_idle", 32'(line3[41]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
